// File: rtl/sparse_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : sparse_mac_pipe
// Description : Pipelined sparse dot-product engine. Each beat carries K
//               signed DW-bit matrix/vector lane pairs with a per-lane valid
//               mask. The beat is captured, multiplied, and reduced through a
//               registered log2(K)-level adder tree. A row accumulator closes
//               the row on in_last.
//               Optional feature macro: SPMAC_SAT_EN. When it is defined, the
//               accumulator saturates and out_ovf is set. When it is not
//               defined, the accumulator wraps and out_ovf stays 0.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - input beat handshake
//               in_mat/in_vec       - K packed signed lanes, lane i = [DW*i +: DW]
//               in_mask             - per-lane contribute enable
//               in_last             - final beat of the row
//               out_valid/out_ready - row result handshake
//               out_sum             - signed row dot product (ACCW bits)
//               out_nnz             - saturating count of set mask bits in row
//               out_ovf             - row accumulation clamped (SPMAC_SAT_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module sparse_mac_pipe #(
  parameter int K    = 4,
  parameter int DW   = 8,
  parameter int ACCW = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DW*K-1:0]        in_mat,
  input  logic [DW*K-1:0]        in_vec,
  input  logic [K-1:0]           in_mask,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic signed [ACCW-1:0] out_sum,
  output logic [15:0]            out_nnz,
  output logic                   out_ovf
);

  localparam int LG   = $clog2(K);
  localparam int PW   = LG + 1;       // popcount width for one beat
  localparam int MW   = 2 * DW;       // product width
  localparam int TW   = 2 * DW + LG;  // adder tree output width
  localparam int AW1  = ACCW + 1;

  // The whole pipeline moves as one unit. It is frozen only while a result
  // waits for the consumer.
  logic w_adv;
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  // --------------------------------------------------------------------------
  // Input capture. The operands are registered so that the multipliers start
  // from flops rather than from the fetch logic.
  // --------------------------------------------------------------------------
  logic            r_i_valid;
  logic            r_i_last;
  logic [DW*K-1:0] r_i_mat;
  logic [DW*K-1:0] r_i_vec;
  logic [K-1:0]    r_i_mask;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_i_valid <= 1'b0;
      r_i_last  <= 1'b0;
      r_i_mat   <= '0;
      r_i_vec   <= '0;
      r_i_mask  <= '0;
    end else if (w_adv) begin
      r_i_valid <= in_valid;
      r_i_last  <= in_last;
      r_i_mat   <= in_mat;
      r_i_vec   <= in_vec;
      r_i_mask  <= in_mask;
    end
  end

  // Masked lane products and the beat's popcount
  logic signed [MW-1:0] w_prod [K];
  logic [PW-1:0]        w_pop;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < K; i++) begin
      w_prod[i] = MW'($signed(r_i_mat[DW*i +: DW])) * MW'($signed(r_i_vec[DW*i +: DW]));
      if (!r_i_mask[i]) begin
        w_prod[i] = '0;
      end
      w_pop = w_pop + PW'(r_i_mask[i]);
    end
  end

  // --------------------------------------------------------------------------
  // Level 0 holds the registered products (stage M). Levels 1..LG are
  // the pairwise adder tree. Each level grows by one bit, so no add can
  // overflow. Valid, last and popcount travel with the data.
  // --------------------------------------------------------------------------
  for (genvar l = 0; l <= LG; l++) begin : g_lvl
    localparam int N = K >> l;
    localparam int W = 2 * DW + l;

    logic signed [W-1:0] r_sum [N];
    logic                r_valid;
    logic                r_last;
    logic [PW-1:0]       r_pop;

    if (l == 0) begin : g_mul
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_pop   <= '0;
          for (int i = 0; i < N; i++) r_sum[i] <= '0;
        end else if (w_adv) begin
          r_valid <= r_i_valid;
          r_last  <= r_i_last;
          r_pop   <= w_pop;
          for (int i = 0; i < N; i++) r_sum[i] <= w_prod[i];
        end
      end
    end else begin : g_add
      always_ff @(posedge clk) begin
        if (rst) begin
          r_valid <= 1'b0;
          r_last  <= 1'b0;
          r_pop   <= '0;
          for (int j = 0; j < N; j++) r_sum[j] <= '0;
        end else if (w_adv) begin
          r_valid <= g_lvl[l-1].r_valid;
          r_last  <= g_lvl[l-1].r_last;
          r_pop   <= g_lvl[l-1].r_pop;
          for (int j = 0; j < N; j++) begin
            r_sum[j] <= W'(g_lvl[l-1].r_sum[2*j]) + W'(g_lvl[l-1].r_sum[2*j+1]);
          end
        end
      end
    end
  end

  logic signed [TW-1:0] w_tree;
  logic                 w_t_valid;
  logic                 w_t_last;
  logic [PW-1:0]        w_t_pop;

  assign w_tree    = g_lvl[LG].r_sum[0];
  assign w_t_valid = g_lvl[LG].r_valid;
  assign w_t_last  = g_lvl[LG].r_last;
  assign w_t_pop   = g_lvl[LG].r_pop;

  // --------------------------------------------------------------------------
  // Row accumulator (stage A)
  // --------------------------------------------------------------------------
  logic signed [ACCW-1:0] r_acc;
  logic [15:0]            r_cnt;
  logic                   r_ovf_row;

  logic signed [ACCW-1:0] w_ext;
  logic signed [ACCW-1:0] w_sum;
  logic                   w_clamp;
  logic [16:0]            w_cnt_wide;
  logic [15:0]            w_cnt;

  assign w_ext = ACCW'(w_tree);

`ifdef SPMAC_SAT_EN
  // One guard bit shows a signed overflow. A positive overflow clamps to
  // max, and a negative overflow clamps to min.
  logic signed [AW1-1:0] w_wide;

  always_comb begin
    w_wide  = AW1'(r_acc) + AW1'(w_ext);
    w_clamp = (w_wide[ACCW] != w_wide[ACCW-1]);
    if (!w_clamp) begin
      w_sum = w_wide[ACCW-1:0];
    end else if (w_wide[ACCW]) begin
      w_sum = {1'b1, {(ACCW-1){1'b0}}};
    end else begin
      w_sum = {1'b0, {(ACCW-1){1'b1}}};
    end
  end
`else
  assign w_sum   = r_acc + w_ext;
  assign w_clamp = 1'b0;
`endif

  // The non-zero count saturates instead of wrapping on very long rows.
  assign w_cnt_wide = {1'b0, r_cnt} + 17'(w_t_pop);
  assign w_cnt      = w_cnt_wide[16] ? 16'hFFFF : w_cnt_wide[15:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_nnz   <= '0;
      out_ovf   <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf_row <= 1'b0;
    end else if (w_adv) begin
      if (w_t_valid && w_t_last) begin
        // Close the row. The accumulator restarts in the same cycle, so the
        // next row may follow directly.
        out_valid <= 1'b1;
        out_sum   <= w_sum;
        out_nnz   <= w_cnt;
        out_ovf   <= r_ovf_row | w_clamp;
        r_acc     <= '0;
        r_cnt     <= '0;
        r_ovf_row <= 1'b0;
      end else begin
        // Any held result was consumed on this edge (or none was present).
        out_valid <= 1'b0;
        if (w_t_valid) begin
          r_acc     <= w_sum;
          r_cnt     <= w_cnt;
          r_ovf_row <= r_ovf_row | w_clamp;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sparse_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_sparse_mac_pipe
// Description : Self-checking bench for sparse_mac_pipe. It drives a 32-bit
//               accumulator instance and an 18-bit accumulator instance from
//               the same input stream. Each row result is compared with
//               expected values. A row-level arithmetic model builds these
//               values when each beat is accepted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sparse_mac_pipe;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic               in_ready18;
  logic [31:0]        in_mat = '0;
  logic [31:0]        in_vec = '0;
  logic [3:0]         in_mask = '0;
  logic               in_last = 1'b0;
  logic               out_ready = 1'b1;
  logic               ov32, ov18;
  logic signed [31:0] sum32;
  logic signed [17:0] sum18;
  logic [15:0]        nnz32, nnz18;
  logic               ovf32, ovf18;

  always #5 clk = ~clk;

  sparse_mac_pipe #(.K(4), .DW(8), .ACCW(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mat(in_mat), .in_vec(in_vec), .in_mask(in_mask), .in_last(in_last),
    .out_valid(ov32), .out_ready(out_ready), .out_sum(sum32),
    .out_nnz(nnz32), .out_ovf(ovf32)
  );

  sparse_mac_pipe #(.K(4), .DW(8), .ACCW(18)) dut18 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready18),
    .in_mat(in_mat), .in_vec(in_vec), .in_mask(in_mask), .in_last(in_last),
    .out_valid(ov18), .out_ready(out_ready), .out_sum(sum18),
    .out_nnz(nnz18), .out_ovf(ovf18)
  );

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  bit rnd_ready = 1'b0;

  typedef struct {
    longint s32;
    bit     o32;
    int     nnz;
    longint s18;
    bit     o18;
  } exp_t;

  exp_t   exp_q[$];
  longint row32 = 0, row18 = 0;
  bit     rowo32 = 0, rowo18 = 0;
  int     rownnz = 0;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Adds one beat into a w-bit signed accumulator. The accumulator saturates
  // when the feature macro is defined. Otherwise it wraps.
  task automatic acc_add(input longint a, input longint b, input int w,
                         output longint r, output bit ov);
    longint t, m, mx, mn;
    t  = a + b;
    m  = longint'(1) << w;
    mx = (m / 2) - 1;
    mn = -(m / 2);
    ov = 1'b0;
`ifdef SPMAC_SAT_EN
    if (t > mx) begin t = mx; ov = 1'b1; end
    if (t < mn) begin t = mn; ov = 1'b1; end
`else
    t = t & (m - 1);
    if (t > mx) t = t - m;
`endif
    r = t;
  endtask

  task automatic model_beat(input logic [31:0] m, input logic [31:0] v,
                            input logic [3:0] k, input logic l);
    longint bs = 0;
    int     pc = 0;
    bit     o;
    exp_t   e;
    for (int i = 0; i < 4; i++) begin
      if (k[i]) begin
        bs += longint'($signed(m[8*i +: 8])) * longint'($signed(v[8*i +: 8]));
        pc++;
      end
    end
    acc_add(row32, bs, 32, row32, o); rowo32 |= o;
    acc_add(row18, bs, 18, row18, o); rowo18 |= o;
    rownnz = (rownnz + pc > 65535) ? 65535 : rownnz + pc;
    if (l) begin
      e.s32 = row32; e.o32 = rowo32; e.nnz = rownnz;
      e.s18 = row18; e.o18 = rowo18;
      exp_q.push_back(e);
      row32 = 0; row18 = 0; rowo32 = 0; rowo18 = 0; rownnz = 0;
    end
  endtask

  // Presents one beat and returns one time step after the edge that accepted it.
  task automatic send(input logic [31:0] m, input logic [31:0] v,
                      input logic [3:0] k, input logic l);
    int guard = 0;
    in_mat = m; in_vec = v; in_mask = k; in_last = l; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(posedge clk);
      #1;
      if (rnd_ready) out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
      $display("FAIL accept_timeout: run aborted, %0d checks, %0d errors", checks, errors);
      $fatal(1, "accept timeout");
    end
    @(posedge clk);
    model_beat(m, v, k, l);
    #1 in_valid = 1'b0;
  endtask

  // Counts rising edges until out_valid is seen high.
  task automatic wait_valid(output int lat);
    lat = 0;
    while (lat < 30) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (ov32 === 1'b1) return;
    end
    chk("result_timeout", ov32, 1);
  endtask

  // Result scoreboard. One comparison set is made for each output handshake.
  always @(negedge clk) begin
    if (!rst && ov32 === 1'b1 && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", ov32, 0);
      end else begin
        chk("sum32", sum32, exp_q[0].s32);
        chk("nnz32", nnz32, exp_q[0].nnz);
        chk("ovf32", ovf32, exp_q[0].o32);
        chk("valid18", ov18, 1);
        chk("sum18", sum18, exp_q[0].s18);
        chk("nnz18", nnz18, exp_q[0].nnz);
        chk("ovf18", ovf18, exp_q[0].o18);
        void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] ONES  = 32'h0101_0101;
  localparam logic [31:0] M1234 = 32'h0403_0201;
  localparam logic [31:0] V5678 = 32'h0807_0605;
  localparam logic [31:0] NEG   = 32'h8080_8080;

  initial begin
    int            lat;
    int            hs0;
    int            len;
    longint        held;
    logic [31:0]   rm, rv;

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", ov32, 0);
    chk("rst_out_sum", sum32, 0);
    chk("rst_out_nnz", nnz32, 0);
    chk("rst_out_ovf", ovf32, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Single full-mask beat: the result and its latency
    send(M1234, V5678, 4'b1111, 1'b1);
    wait_valid(lat);
    chk("latency", lat, 4);
    chk("tp_sum70", sum32, 70);
    chk("tp_nnz4", nnz32, 4);
    repeat (2) @(posedge clk); #1;

    // Partial mask
    send(M1234, V5678, 4'b0101, 1'b1);
    wait_valid(lat);
    chk("tp_sum26", sum32, 26);
    chk("tp_nnz2", nnz32, 2);
    repeat (2) @(posedge clk); #1;

    // Three beats at the most negative extremes
    send(NEG, NEG, 4'b1111, 1'b0);
    send(NEG, NEG, 4'b1111, 1'b0);
    send(NEG, NEG, 4'b1111, 1'b1);
    wait_valid(lat);
    chk("tp_sum196608", sum32, 196608);
    chk("tp_nnz12", nnz32, 12);
    repeat (2) @(posedge clk); #1;

    // Overflow at ACCW=18 with two beats
    send(NEG, NEG, 4'b1111, 1'b0);
    send(NEG, NEG, 4'b1111, 1'b1);
    wait_valid(lat);
`ifdef SPMAC_SAT_EN
    chk("tp_sat_sum18", sum18, 131071);
    chk("tp_sat_ovf18", ovf18, 1);
`else
    chk("tp_wrap_sum18", sum18, -131072);
    chk("tp_wrap_ovf18", ovf18, 0);
`endif
    repeat (2) @(posedge clk); #1;

    // Backpressure: hold a result while the next beat waits at the input
    out_ready = 1'b0;
    send($urandom(), $urandom(), 4'($urandom_range(0, 15)), 1'b1);
    wait_valid(lat);
    held = exp_q[0].s32;
    in_mat = ONES; in_vec = ONES; in_mask = 4'b1111; in_last = 1'b1; in_valid = 1'b1;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", ov32, 1);
      chk("stall_sum_hold", sum32, held);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(ONES, ONES, 4'b1111, 1'b1);
    wait_valid(lat);
    chk("bp_next_sum4", sum32, 4);
    repeat (2) @(posedge clk); #1;

    // Reset in the middle of a row drops the partial row
    send(M1234, V5678, 4'b1111, 1'b0);
    send(M1234, V5678, 4'b1111, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    row32 = 0; row18 = 0; rowo32 = 0; rowo18 = 0; rownnz = 0;
    hs0 = hs_cnt;
    send(ONES, ONES, 4'b1111, 1'b1);
    wait_valid(lat);
    chk("rst_row_sum4", sum32, 4);
    chk("rst_row_nnz4", nnz32, 4);
    repeat (12) @(posedge clk);
    #1;
    chk("rst_row_pulses", hs_cnt - hs0, 1);

    // Randomised rows with random bubbles and random output backpressure
    rnd_ready = 1'b1;
    for (int r = 0; r < 60; r++) begin
      len = $urandom_range(1, 5);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk); #1;
        end
        out_ready = ($urandom_range(0, 3) != 0);
        rm = $urandom();
        rv = $urandom();
        if ($urandom_range(0, 7) == 0) rm = NEG;
        if ($urandom_range(0, 7) == 0) rv = NEG;
        send(rm, rv, 4'($urandom_range(0, 15)), (b == len - 1));
      end
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sparse_mac_pipe.md
# sparse_mac_pipe

Parametrised, pipelined sparse dot-product engine: K signed DW-bit matrix/vector lane pairs per beat, per-lane valid mask, registered log2(K)-level adder tree, and a row accumulator closed by an end-of-row flag. It is the generalised successor of the fixed 4-lane multiply/map/add pipeline. It sits between the sparse-row fetch logic and the result writeback. Rows of any length stream through with valid/ready flow control on both sides.

## Interface
- K, 4, lane count; power of two, ≥2
- DW, 8, signed element width
- ACCW, 32, signed accumulator/result width; must satisfy ACCW ≥ 2*DW+log2(K)
- clk  in  1  clock, rising edge
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_mat  in  DW*K  matrix lanes; lane i = [DW*i +: DW], signed
- in_vec  in  DW*K  vector lanes, same packing
- in_mask  in  K  bit i=1: lane i contributes; 0: lane i forced to zero product
- in_last  in  1  beat is the final beat of its row
- out_valid  out  1  row result valid
- out_ready  in  1  row result consumed when out_valid && out_ready
- out_sum  out  ACCW  signed row dot product
- out_nnz  out  16  count of set mask bits over the row, saturating at 16'hFFFF
- out_ovf  out  1  row accumulation overflowed (see Configuration)

## Operation
- Global advance: adv = !out_valid || out_ready; in_ready = adv (combinational). All pipeline registers load only when adv; otherwise every stage holds.
- Stage M: per lane, p_i = mask_i ? signed(mat_i)*signed(vec_i) : 0, width 2*DW; registered with valid, last, popcount(mask).
- Stages T1..T(log2 K): pairwise adds, each level +1 bit, sign-extended; valid/last/count travel alongside.
- Stage A (accumulator): on a valid tree beat, sum = acc + sext(tree_out). Non-last beat: acc <= sum, cnt <= cnt+pop. Last beat: out_sum <= sum, out_nnz <= cnt+pop, out_ovf <= ovf_row | this-beat overflow, out_valid <= 1; acc, cnt, ovf_row cleared in the same cycle.
- A beat with in_mask = 0 is accepted normally and contributes 0 to sum and count. A single-beat row (in_last on first beat) is legal.
- out_valid clears on handshake unless a new result loads in the same cycle; back-to-back rows produce consecutive out_valid cycles.
- Reset: out_valid=0, out_sum=0, out_nnz=0, out_ovf=0, all stage valids=0, acc/cnt/ovf_row=0; in_ready=1 in the first cycle after reset. Reset mid-row discards all in-flight beats and the partial row; no result is emitted for them.

## Timing
- Latency L = 2 + log2(K) cycles from the accepting edge of a row's last beat to out_valid high, absent stalls (K=4: 4).
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, in_ready=0, and out_sum/out_nnz/out_ovf and all stages hold unchanged.
- Simultaneous handshake and new result: the old result is consumed and the new one is loaded on the same edge, with out_valid staying 1.

## Configuration
- SPMAC_SAT_EN defined: the accumulator add saturates to [-2^(ACCW-1), 2^(ACCW-1)-1]. Any clamp in the row sets a sticky ovf_row, reported as out_ovf with the row result. After a clamp, the accumulator continues from the clamped value.
- Not defined: the add wraps modulo 2^ACCW and out_ovf is tied 0.

## Test plan
- K=4, DW=8, ACCW=32. One beat: mat lanes0..3={1,2,3,4}, vec={5,6,7,8}, mask=4'b1111, last → out_sum=70, out_nnz=4, out_valid 4 cycles after accept.
- Same data, mask=4'b0101, last → out_sum=26 (1*5+3*7), out_nnz=2.
- Three beats, all lanes mat=-128, vec=-128, mask=4'b1111, last on beat 3 → out_sum=196608, out_nnz=12.
- Backpressure: out_ready=0 for 5 cycles after a result appears, with in_valid held high → in_ready=0 and out_sum stable. Then out_ready=1 → the next row (mat=vec=1 all lanes) yields out_sum=4 with no lost or duplicated beat.
- ACCW=18, two beats of -128*-128 on all lanes, with SPMAC_SAT_EN → out_sum=131071, out_ovf=1. Without the macro → out_sum=-131072, out_ovf=0.
- Two non-last beats, then rst for 1 cycle, then one beat mat=vec=1 all lanes, last → out_sum=4, out_nnz=4, exactly one out_valid pulse.
